keypad_emulator: RTL
====================

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Emulates a 4x4 active-low key matrix. It sits on the far end of the row-scan / column-read interface and presses programmed key sets for timed intervals.

Interface
REQ-001 The block SHALL have parameter PRESS_CYCLES, default 1200000, giving the key-held duration in clk cycles (100 ms at 12 MHz); legal range is 1 or more.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 600000, giving the forced all-released duration after each press in clk cycles; legal range is 1 or more.
REQ-003 The block SHALL have parameter WIDTH, default 21, the counter width; it must satisfy 2^WIDTH > max(PRESS_CYCLES, GAP_CYCLES).
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 row  input  4  scan lines from the keypad scanner, active-low; row[r]=0 selects matrix row r.
REQ-007 col  output  4  column lines to the scanner, active-low, registered.
REQ-008 cmd_valid  input  1  command request.
REQ-009 cmd_keys  input  16  key set to press, active-high; bit k = matrix row k/4, column k%4.
REQ-010 cmd_ready  output  1  command can be accepted.
REQ-011 cmd_abort  input  1  terminate the current command.
REQ-012 busy  output  1  a command is in progress.
REQ-013 done  output  1  one-cycle pulse on normal completion.
REQ-014 aborted  output  1  one-cycle pulse on abort completion.

Function
REQ-015 The FSM SHALL have exactly three states:
- IDLE: cmd_ready=1, busy=0.
- PRESS: cmd_ready=0, busy=1.
- GAP: cmd_ready=0, busy=1.
REQ-016 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1. On acceptance, cmd_keys is latched into the 16-bit pressed register, the counter is cleared, and the state moves to PRESS.
REQ-017 cmd_valid while busy=1 SHALL be ignored; cmd_keys changes after acceptance SHALL have no effect.
REQ-018 PRESS SHALL last exactly PRESS_CYCLES cycles. On its last cycle, pressed is cleared to 0, the counter is cleared, and the state moves to GAP.
REQ-019 GAP SHALL last exactly GAP_CYCLES cycles, then the state moves to IDLE.
REQ-020 done SHALL be registered and high only in the first IDLE cycle after a GAP that ran to completion.
REQ-021 A zero cmd_keys SHALL be accepted normally; it acts as a pure delay of PRESS_CYCLES+GAP_CYCLES cycles with col held at 4'hF, then produces done.
REQ-022 row SHALL be registered into row_q each cycle.
REQ-023 col[c] SHALL be registered as 0 iff some r has row_q[r]=0 and pressed[4r+c]=1, and as 1 otherwise. Response latency from row to col is 2 clk cycles.
REQ-024 Multiple simultaneously-low row bits SHALL combine as a wired-AND of the selected rows. The block models ideal switches: no ghosting suppression and no bounce.
REQ-025 cmd_abort=1 in PRESS or GAP SHALL, at the next edge, clear pressed and the counter, move the state to IDLE, and pulse aborted for the first IDLE cycle; done SHALL NOT pulse for an aborted command.
REQ-026 cmd_abort=1 in IDLE SHALL be ignored; with cmd_valid=1 in the same IDLE cycle, the command is accepted.
REQ-027 If cmd_abort=1 coincides with the last PRESS or last GAP cycle, abort SHALL take precedence: aborted pulses and done does not.
REQ-028 A new command presented during a done or aborted cycle SHALL be accepted at that cycle's edge, allowing back-to-back commands.
REQ-029 done and aborted SHALL never be high in the same cycle.

Reset
REQ-030 While rst=1 at a rising edge, the block SHALL set:
- state = IDLE
- pressed = 16'h0000
- counter = 0
- row_q = 4'hF
- col = 4'hF
- done = 0, aborted = 0
- consequently cmd_ready = 1, busy = 0
REQ-031 Reset asserted mid-PRESS or mid-GAP SHALL discard the command silently (no done, no aborted), with col=4'hF after the reset edge.

Verification (PRESS_CYCLES=8, GAP_CYCLES=4, WIDTH=4)
REQ-032 Reset: assert rst 2 cycles, with row=4'b0000 -> col=4'hF, cmd_ready=1, busy=0, done=0.
REQ-033 Single key: accept cmd_keys=16'h0020 at edge t0.
- With row=4'b1101 -> col=4'b1101 from t0+2 through t0+9.
- With row=4'b1110 -> col=4'hF.
- busy=1 for cycles t0+1..t0+12; done=1 only at t0+13.
REQ-034 Multi-key: cmd_keys=16'h8001 with row=4'b0000 -> col=4'b0110 during PRESS; col=4'hF during GAP.
REQ-035 Abort: cmd_abort=1 in the 3rd PRESS cycle -> next cycle IDLE, aborted=1 for 1 cycle, done never pulses, col=4'hF one cycle later.
REQ-036 Busy/back-to-back: cmd_valid held high throughout the command.
- The second command is accepted only on the done cycle.
- done and aborted are never co-asserted.
- Abort on the last GAP cycle yields aborted, not done.
REQ-037 Reset mid-PRESS: rst=1 for 1 cycle during PRESS -> col=4'hF and cmd_ready=1 after the edge, with no done and no aborted.

Source files
------------

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 active-low key matrix emulator with timed press/gap sequencing
module keypad_emulator #(
  parameter int PRESS_CYCLES = 1200000,
  parameter int GAP_CYCLES   = 600000,
  parameter int WIDTH        = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_keys,
  output logic        cmd_ready,
  input  logic        cmd_abort,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP} state_t;

  localparam logic [WIDTH-1:0] PRESS_LAST = WIDTH'(PRESS_CYCLES - 1);
  localparam logic [WIDTH-1:0] GAP_LAST   = WIDTH'(GAP_CYCLES - 1);

  state_t            state;
  logic [15:0]       pressed;
  logic [WIDTH-1:0]  counter;
  logic [3:0]        row_q;
  logic [3:0]        col_next;

  // A column is pulled low when any selected (low) row has its key at that column pressed.
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign col_next[c] = &(row_q | ~{pressed[12+c], pressed[8+c], pressed[4+c], pressed[c]});
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pressed <= 16'h0000;
      counter <= '0;
      row_q   <= 4'hF;
      col     <= 4'hF;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      row_q   <= row;
      col     <= col_next;
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            pressed <= cmd_keys;
            counter <= '0;
            state   <= S_PRESS;
          end
        end
        S_PRESS: begin
          // Abort wins even on the final press cycle.
          if (cmd_abort) begin
            pressed <= 16'h0000;
            counter <= '0;
            state   <= S_IDLE;
            aborted <= 1'b1;
          end else if (counter == PRESS_LAST) begin
            pressed <= 16'h0000;
            counter <= '0;
            state   <= S_GAP;
          end else begin
            counter <= counter + WIDTH'(1);
          end
        end
        S_GAP: begin
          if (cmd_abort) begin
            pressed <= 16'h0000;
            counter <= '0;
            state   <= S_IDLE;
            aborted <= 1'b1;
          end else if (counter == GAP_LAST) begin
            counter <= '0;
            state   <= S_IDLE;
            done    <= 1'b1;
          end else begin
            counter <= counter + WIDTH'(1);
          end
        end
        default: begin
          pressed <= 16'h0000;
          counter <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
